// File: rtl/alu_sequencer_if.sv
// Command channel between a command source and the ALU sequencer.
// The source drives the command fields and cmd_valid; the sequencer returns cmd_ready.
interface alu_sequencer_if #(
  parameter int unsigned N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd;
  logic [1:0]   cmd_ra;
  logic [1:0]   cmd_rb;
  logic         cmd_use_imm;
  logic [N-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_use_imm, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_use_imm, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: latches a command and its operands, drives an external ALU,
// captures the result and flags, then writes back into a 4-entry register file.
module alu_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_sequencer_if.slave cmd,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_cntr,
  input  logic [N-1:0] alu_r,
  input  logic [3:0]   alu_flags,
  output logic [3:0]   flags,
  output logic         done,
  output logic         err,
  output logic         busy,
  input  logic [1:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam int unsigned NREG = 4;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t       state_q, state_d;
  logic         accept, capture, retire;
  logic [1:0]   rd_q;
  logic [N-1:0] res_q;
  logic [3:0]   flg_q;
  logic [N-1:0] regs [NREG];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: if (cmd.cmd_valid) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: begin
        retire  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign dbg_data      = regs[dbg_addr];

  // Operand latch, ALU capture, write-back; alu_cntr doubles as the latched opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cntr <= 3'd0;
      rd_q     <= 2'd0;
      res_q    <= '0;
      flg_q    <= 4'd0;
      flags    <= 4'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= capture;
      err  <= capture && (alu_cntr[2:1] == 2'b11);
      if (accept) begin
        alu_cntr <= cmd.cmd_op;
        rd_q     <= cmd.cmd_rd;
        alu_a    <= regs[cmd.cmd_ra];
        alu_b    <= cmd.cmd_use_imm ? cmd.cmd_imm : regs[cmd.cmd_rb];
      end
      if (capture) begin
        res_q <= alu_r;
        flg_q <= alu_flags;
      end
      if (retire) begin
        case (alu_cntr)
          3'd0, 3'd1: begin
            regs[rd_q] <= res_q;
            flags      <= flg_q;
          end
          3'd2, 3'd3, 3'd4, 3'd5: begin
            // Logic and move ops refresh Z/N only; C and V keep their arithmetic history
            regs[rd_q] <= res_q;
            flags[0]   <= flg_q[0];
            flags[2]   <= flg_q[2];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, command-level model of the
// register file and flags, directed scenarios with literal expectations, then random traffic.
module tb_alu_sequencer;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] alu_a, alu_b, alu_r, dbg_data;
  logic [2:0]   alu_cntr;
  logic [3:0]   alu_flags, flags;
  logic         done, err, busy;
  logic [1:0]   dbg_addr;

  always #5 clk = ~clk;

  alu_sequencer_if #(.N(N)) cmd_if ();

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntr(alu_cntr),
    .alu_r(alu_r), .alu_flags(alu_flags), .flags(flags),
    .done(done), .err(err), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: returns {V, N, C, Z, result}
  function automatic logic [N+3:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0];
        c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~b;
      3'd5: r = b;
      default: r = '0;
    endcase
    if (op >= 3'd6) return {4'b0000, r};
    return {v, r[N-1], c, (r == '0), r};
  endfunction

  always_comb {alu_flags, alu_r} = alu_fn(alu_cntr, alu_a, alu_b);

  // Command-level model: pend 0 = idle, 1 = operands latched, 2 = retiring
  logic [N-1:0] m_r [4];
  logic [3:0]   m_flags;
  int           m_pend;
  logic [2:0]   m_op;
  logic [1:0]   m_rd;
  logic [N-1:0] m_a, m_b;
  bit           last_acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_flags = 4'd0; m_pend = 0; m_op = 3'd0; m_rd = 2'd0; m_a = '0; m_b = '0;
  endtask

  task automatic compare_all();
    chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(m_pend == 0));
    chk("busy",      32'(busy),     32'(m_pend != 0));
    chk("done",      32'(done),     32'(m_pend == 2));
    chk("err",       32'(err),      32'(m_pend == 2 && m_op >= 3'd6));
    chk("flags",     32'(flags),    32'(m_flags));
    chk("alu_a",     32'(alu_a),    32'(m_a));
    chk("alu_b",     32'(alu_b),    32'(m_b));
    chk("alu_cntr",  32'(alu_cntr), 32'(m_op));
    chk("dbg_data",  32'(dbg_data), 32'(m_r[dbg_addr]));
  endtask

  task automatic step();
    logic         acc;
    logic [N+3:0] t;
    acc = rst_n && cmd_if.cmd_valid && (m_pend == 0);
    @(posedge clk);
    last_acc = acc;
    if (!rst_n) model_reset();
    else if (m_pend == 2) begin
      t = alu_fn(m_op, m_a, m_b);
      if (m_op <= 3'd1) begin
        m_r[m_rd] = t[N-1:0];
        m_flags   = t[N+3:N];
      end else if (m_op <= 3'd5) begin
        m_r[m_rd]  = t[N-1:0];
        m_flags[0] = t[N];
        m_flags[2] = t[N+2];
      end
      m_pend = 0;
    end else if (m_pend == 1) m_pend = 2;
    else if (acc) begin
      m_op = cmd_if.cmd_op;
      m_rd = cmd_if.cmd_rd;
      m_a  = m_r[cmd_if.cmd_ra];
      m_b  = cmd_if.cmd_use_imm ? cmd_if.cmd_imm : m_r[cmd_if.cmd_rb];
      m_pend = 1;
    end
    #1 compare_all();
    dbg_addr = 2'($urandom);
    #1 chk("dbg_data_rand", 32'(dbg_data), 32'(m_r[dbg_addr]));
  endtask

  task automatic drive_cmd(input bit v, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input bit ui, input logic [N-1:0] imm);
    cmd_if.cmd_valid = v; cmd_if.cmd_op = op; cmd_if.cmd_rd = rd; cmd_if.cmd_ra = ra;
    cmd_if.cmd_rb = rb; cmd_if.cmd_use_imm = ui; cmd_if.cmd_imm = imm;
  endtask

  // Issue one command and measure done latency (accept cycle = 1) and cmd_ready-low cycles
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                       input bit ui, input logic [N-1:0] imm, output int lat, output int lowc, output logic got_err);
    int k;
    drive_cmd(1'b1, op, rd, ra, rb, ui, imm);
    lat = -1; lowc = 0; got_err = 1'b0; k = 0;
    do begin step(); k++; end while (!last_acc && k < 20);
    if (!last_acc) chk("accept_timeout", 32'(0), 32'(1));
    cmd_if.cmd_valid = 1'b0;
    if (cmd_if.cmd_ready !== 1'b1) lowc++;
    k = 1;
    while (cmd_if.cmd_ready !== 1'b1 && k < 20) begin
      step(); k++;
      if (done === 1'b1 && lat < 0) begin lat = k; got_err = err; end
      if (cmd_if.cmd_ready !== 1'b1) lowc++;
    end
  endtask

  task automatic rd_chk(input string name, input logic [1:0] idx, input logic [N-1:0] exp);
    dbg_addr = idx;
    #1 chk(name, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, lowc;
    logic e;
    logic [N-1:0] imm;
    drive_cmd(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, '0);
    dbg_addr = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) rd_chk("reset_reg", 2'(i), 8'h00);
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("reset_busy",  32'(busy), 32'h0);

    issue(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, lat, lowc, e);
    chk("mov1_latency", 32'(lat), 32'd2);
    issue(3'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, lat, lowc, e);
    chk("mov2_latency", 32'(lat), 32'd2);
    rd_chk("mov_r1", 2'd1, 8'h7F);
    rd_chk("mov_r2", 2'd2, 8'h01);
    chk("mov_flags", 32'(flags), 32'h0);

    issue(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, lat, lowc, e);
    chk("add_ready_low", 32'(lowc), 32'd2);
    rd_chk("add_r3", 2'd3, 8'h80);
    chk("add_flags", 32'(flags), 32'hC);

    issue(3'd1, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, lat, lowc, e);
    rd_chk("sub_r0", 2'd0, 8'h00);
    chk("sub_flags", 32'(flags), 32'h3);
    issue(3'd2, 2'd0, 2'd3, 2'd0, 1'b1, 8'h0F, lat, lowc, e);
    rd_chk("and_r0", 2'd0, 8'h00);
    chk("and_flags_c_kept", 32'(flags), 32'h3);

    issue(3'd6, 2'd2, 2'd0, 2'd0, 1'b0, 8'h00, lat, lowc, e);
    chk("unimp_done_latency", 32'(lat), 32'd2);
    chk("unimp_err", 32'(e), 32'h1);
    rd_chk("unimp_r2", 2'd2, 8'h01);
    chk("unimp_flags", 32'(flags), 32'h3);

    // Reset while the add is in EXEC
    drive_cmd(1'b1, 3'd0, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00);
    step();
    chk("rst_accept", 32'(last_acc), 32'h1);
    cmd_if.cmd_valid = 1'b0;
    chk("rst_busy_exec", 32'(busy), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    step(); step();
    chk("rst_no_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    rd_chk("rst_r1", 2'd1, 8'h00);
    chk("rst_flags", 32'(flags), 32'h0);
    issue(3'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, lat, lowc, e);
    chk("post_rst_latency", 32'(lat), 32'd2);
    rd_chk("post_rst_r1", 2'd1, 8'h55);

    // Random traffic with occasional asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: imm = 8'h7F;
        1: imm = 8'h80;
        2: imm = 8'hFF;
        default: imm = N'($urandom);
      endcase
      drive_cmd(1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 2'($urandom),
                2'($urandom), 1'($urandom), imm);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Single-issue command sequencer that owns one combinational N-bit ALU.
- Accepts one command per transaction over a valid/ready handshake and reads operands from a 4-entry internal register file.
- Drives the ALU, captures the result and the ALU flags, writes back, and reports completion.
- Sits between the lab top level (switches or testbench command source) and the ALU instance.

Parameters:
- N, 8, data width of registers, immediate and ALU operands.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 100 not B, 101 move B, 110/111 unimplemented.
- cmd_rd  input  2  destination register index.
- cmd_ra  input  2  operand A register index.
- cmd_rb  input  2  operand B register index.
- cmd_use_imm  input  1  1 = operand B taken from cmd_imm instead of register rb.
- cmd_imm  input  N  immediate operand B.
- alu_a  output  N  ALU operand A.
- alu_b  output  N  ALU operand B.
- alu_cntr  output  3  ALU control.
- alu_r  input  N  ALU result (combinational from alu_a/alu_b/alu_cntr).
- alu_flags  input  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- flags  output  4  architectural flag register, same bit order.
- done  output  1  one-cycle pulse when a command retires.
- err  output  1  one-cycle pulse coincident with done for an unimplemented op.
- busy  output  1  high while not in IDLE.
- dbg_addr  input  2  debug read index.
- dbg_data  output  N  combinational read of register dbg_addr.

Behaviour:
- Reset (async, rst_n=0): state IDLE; R0..R3=0; flags=0000; done=0; err=0; alu_a=alu_b=0; alu_cntr=000; latched command cleared. cmd_ready=1 after reset release.
- FSM states: IDLE, EXEC, WB.
- IDLE: cmd_ready=1, busy=0. On cmd_valid&&cmd_ready at edge T, latch op, rd, A=R[ra], and B=(cmd_use_imm ? cmd_imm : R[rb]), then go to EXEC.
- EXEC (cycle T+1): cmd_ready=0, busy=1. alu_a, alu_b and alu_cntr are registered outputs holding the latched values. At the end of the cycle, capture alu_r and alu_flags into internal registers, then go to WB.
- WB (cycle T+2): done=1, busy=1, cmd_ready=0.
  - op 000/001: R[rd]<=captured result; flags<=captured flags (all four).
  - op 010..101: R[rd]<=captured result; flags[0] (Z) and flags[2] (N) updated; C and V retained.
  - op 110/111: no register write, no flag update, err=1.
  - Next state is always IDLE.
- Throughput: one command per 3 cycles. done is asserted 2 cycles after the accepting edge.
- cmd_* inputs are ignored outside the accepting IDLE cycle. A held cmd_valid is accepted again on the next IDLE cycle; the source must drop it after the handshake.
- Operands are read at acceptance. rd may equal ra or rb; the old value is used and the new value is written.
- dbg_data: during WB it shows the pre-write value; the new value is visible from the cycle after WB.
- Width rules: all data is N bits; no sign/zero extension is done by the sequencer. Carry and overflow come only from alu_flags.
- Reset asserted mid-command (EXEC or WB): immediate return to reset state; command discarded; no done or err pulse; no partial write.

Test Plan:
- Reset then dbg_addr 0..3 -> all dbg_data=0x00; flags=0000; cmd_ready=1; busy=0.
- Load via move: op=101, use_imm, imm=0x7F, rd=1; then imm=0x01, rd=2 -> done 2 cycles after each accept; R1=0x7F, R2=0x01; flags Z=0, N=0.
- Add overflow: op=000, ra=1, rb=2, rd=3 -> R3=0x80; flags V=1, N=1, Z=0, C=0; cmd_ready low for exactly 2 cycles.
- Sub to zero with carry: op=001, ra=1, rb=1, rd=0 -> R0=0x00; Z=1, C=1, V=0. Then op=010, imm=0x0F, ra=3 -> R=0x00; Z=1, and C=1 retained.
- Unimplemented: op=110, rd=2 -> done and err pulse together; R2 stays 0x01; flags unchanged.
- Reset during EXEC of op=000, rd=1 -> no done; R1=0x00 after reset; next command accepted normally.
